pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 49 ++++
 rtl/pipe_hazard_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath (master) reports stage contents; the controller (slave) returns enables/flushes.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic [4:0]  ex_wb_addr;
  logic        ex_wb_write_en;
  logic        ex_is_load;
  logic [4:0]  mem_wb_addr;
  logic        mem_wb_write_en;
  logic [4:0]  wb_wb_addr;
  logic        wb_wb_write_en;
  logic        mem_PC_sel;
  logic        mem_data_mem_en;
  logic        dmem_ready;

  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_cnt;
  logic [7:0]  flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_wb_addr, ex_wb_write_en, ex_is_load,
           mem_wb_addr, mem_wb_write_en, wb_wb_addr, wb_wb_write_en,
           mem_PC_sel, mem_data_mem_en, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush,
           fwd_a_sel, fwd_b_sel, ctrl_state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_wb_addr, ex_wb_write_en, ex_is_load,
           mem_wb_addr, mem_wb_write_en, wb_wb_addr, wb_wb_write_en,
           mem_PC_sel, mem_data_mem_en, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush,
           fwd_a_sel, fwd_b_sel, ctrl_state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stalls, branch flushes, data-memory waits,
// operand forwarding selects and saturating stall/flush performance counters.
module pipe_hazard_ctrl (
  input logic                clk,
  input logic                reset,
  pipe_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StLoadStall = 2'd1,
    StFlush     = 2'd2,
    StMemWait   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] stall_cnt_q;
  logic [7:0]  flush_cnt_q;

  logic load_use;
  logic mem_busy;
  logic front_en;    // pc_en and if_id_en
  logic back_en;     // id_ex_en, ex_mem_en, mem_wb_en
  logic flush3;
  logic id_ex_flush;

  // MEM result is younger than WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] mem_addr, input logic mem_we,
                                         input logic [4:0] wb_addr,  input logic wb_we);
    if (mem_we && (mem_addr != 5'd0) && (mem_addr == src)) begin
      return 2'b01;
    end else if (wb_we && (wb_addr != 5'd0) && (wb_addr == src)) begin
      return 2'b10;
    end
    return 2'b00;
  endfunction

  always_comb begin
    load_use = bus.ex_is_load & bus.ex_wb_write_en & (bus.ex_wb_addr != 5'd0) &
               ((bus.ex_wb_addr == bus.id_rs) |
                (bus.id_uses_rt & (bus.ex_wb_addr == bus.id_rt)));
    mem_busy = bus.mem_data_mem_en & ~bus.dmem_ready;

    state_d     = StRun;
    front_en    = 1'b1;
    back_en     = 1'b1;
    flush3      = 1'b0;
    id_ex_flush = 1'b0;

    unique case (state_q)
      StMemWait: begin
        if (!bus.dmem_ready) begin
          front_en = 1'b0;
          back_en  = 1'b0;
          state_d  = StMemWait;
        end else if (bus.mem_PC_sel) begin
          flush3  = 1'b1;
          state_d = StFlush;
        end
      end
      default: begin
        if (mem_busy) begin
          front_en = 1'b0;
          back_en  = 1'b0;
          state_d  = StMemWait;
        end else if (bus.mem_PC_sel) begin
          flush3  = 1'b1;
          state_d = StFlush;
        end else if (load_use && (state_q != StFlush)) begin
          front_en    = 1'b0;
          id_ex_flush = 1'b1;
          state_d     = StLoadStall;
        end
      end
    endcase
  end

  assign bus.pc_en        = front_en;
  assign bus.if_id_en     = front_en;
  assign bus.id_ex_en     = back_en;
  assign bus.ex_mem_en    = back_en;
  assign bus.mem_wb_en    = back_en;
  assign bus.if_id_flush  = flush3;
  assign bus.id_ex_flush  = flush3 | id_ex_flush;
  assign bus.ex_mem_flush = flush3;

  assign bus.fwd_a_sel = fwd_sel(bus.id_rs, bus.mem_wb_addr, bus.mem_wb_write_en,
                                 bus.wb_wb_addr, bus.wb_wb_write_en);
  assign bus.fwd_b_sel = fwd_sel(bus.id_rt, bus.mem_wb_addr, bus.mem_wb_write_en,
                                 bus.wb_wb_addr, bus.wb_wb_write_en);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StRun;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      if (!front_en && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (flush3 && (flush_cnt_q != 8'hFF)) begin
        flush_cnt_q <= flush_cnt_q + 8'd1;
      end
    end
  end

  assign bus.ctrl_state = state_q;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;

endmodule
